// File: rtl/status_beacon.sv
// rtl/status_beacon.sv - Wishbone-attached test-status beacon driving stage codes onto user I/O
//
// Firmware writes stage codes into a small queue. Each dequeued code is held on
// io_out[4:0] for at least HOLD_CYCLES cycles. A sticky error flag bypasses the
// queue and appears on io_out[5] as soon as the write is sampled.
//
// Ports:
//   wb_clk_i   - clock
//   rst_n      - asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_dat_i[31:0]
//              - Wishbone slave request (stb already address-qualified)
//   wbs_ack_o  - single-cycle acknowledge
//   wbs_dat_o  - status read data, valid with ack
//   io_out[5:0]- {error, displayed stage}
//   io_oeb[5:0]- output-enable bar, always driving
module status_beacon #(
  parameter int HOLD_CYCLES = 48,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [5:0]  io_out,
  output logic [5:0]  io_oeb
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [4:0]      disp_q, disp_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [4:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic req, wr, push_req, push, pop, set_err, clr, full, empty;
  logic unused_bits;

  assign unused_bits = ^{wbs_sel_i[2:1], wbs_dat_i[30:6]};

  always_comb begin
    // A request is only taken while ack is low, so a held strobe acks every other cycle.
    req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    wr       = req & wbs_we_i;
    push_req = wr & wbs_sel_i[0];
    set_err  = push_req & wbs_dat_i[5];
    clr      = wr & wbs_sel_i[3] & wbs_dat_i[31];
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);

    state_d = state_q;
    hold_d  = hold_q;
    disp_d  = disp_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          disp_d  = mem_q[rd_ptr_q];
          hold_d  = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if (!empty) begin
          // Reload without passing through IDLE keeps codes exactly HOLD_CYCLES apart.
          pop    = 1'b1;
          disp_d = mem_q[rd_ptr_q];
          hold_d = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    push = push_req & (~full | pop);

    ovf_d = ovf_q;
    if (push_req & full & ~pop) ovf_d = 1'b1;
    if (clr) ovf_d = 1'b0;

    err_d = err_q;
    if (clr) err_d = 1'b0;
    if (set_err) err_d = 1'b1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wbs_dat_i[4:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ack_d = req;
    dat_d = req ? {ovf_q, 20'b0, 3'(count_q), full, empty, err_q, disp_q} : 32'h0;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      disp_q   <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      disp_q   <= disp_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = {err_q, disp_q};
  assign io_oeb    = 6'b000000;

endmodule
